// File: rtl/vball_gfx_server.sv
// vball_gfx_server: graphics-ROM read responder for the BG and sprite renderers.
// Define VBALL_GFX_CACHE_EN to add a one-word cache per client.
module vball_gfx_server #(
  parameter int AW = 19
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] bg_addr,
  input  logic          bg_read,
  output logic [7:0]    bg_data,
  output logic          bg_valid,
  input  logic [AW-1:0] spr_addr,
  input  logic          spr_read,
  output logic [7:0]    spr_data,
  output logic          spr_valid,
  output logic [AW-2:0] rom_addr,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [15:0]   rom_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic OWN_BG  = 1'b0;
  localparam logic OWN_SPR = 1'b1;

  state_t        state, state_n;
  logic          owner, owner_n;
  logic [AW-2:0] waddr_q, waddr_n;
  logic [15:0]   word_q;
  logic          arb_bg, arb_spr;

  logic          bg_rd_q, spr_rd_q;
  logic [AW-1:0] bg_ad_q, spr_ad_q;
  logic          bg_pend, spr_pend;
  logic          bg_pend_n, spr_pend_n;
  logic          bg_det, spr_det;
  logic          bg_hit, spr_hit;
  logic          bg_fly, spr_fly;
  logic          bg_serve, spr_serve;
  logic [7:0]    bg_wbyte, spr_wbyte;
  logic [7:0]    bg_hbyte, spr_hbyte;

  assign bg_det  = bg_read && (!bg_rd_q || bg_addr != bg_ad_q);
  assign spr_det = spr_read && (!spr_rd_q || spr_addr != spr_ad_q);

  assign bg_fly  = state == S_ISSUE && owner == OWN_BG;
  assign spr_fly = state == S_ISSUE && owner == OWN_SPR;

  assign bg_serve  = state == S_DONE && owner == OWN_BG &&
                     bg_read && waddr_q == bg_addr[AW-1:1];
  assign spr_serve = state == S_DONE && owner == OWN_SPR &&
                     spr_read && waddr_q == spr_addr[AW-1:1];

  assign bg_wbyte  = bg_addr[0] ? word_q[15:8] : word_q[7:0];
  assign spr_wbyte = spr_addr[0] ? word_q[15:8] : word_q[7:0];

`ifdef VBALL_GFX_CACHE_EN
  logic [AW-2:0] bg_tag, spr_tag;
  logic [15:0]   bg_cw, spr_cw;
  logic          bg_cv, spr_cv;

  assign bg_hit  = bg_det && bg_cv && bg_tag == bg_addr[AW-1:1];
  assign spr_hit = spr_det && spr_cv && spr_tag == spr_addr[AW-1:1];
  assign bg_hbyte  = bg_addr[0] ? bg_cw[15:8] : bg_cw[7:0];
  assign spr_hbyte = spr_addr[0] ? spr_cw[15:8] : spr_cw[7:0];

  // Filled on every delivered ROM word; only reset invalidates.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bg_cv   <= 1'b0;
      bg_tag  <= '0;
      bg_cw   <= '0;
      spr_cv  <= 1'b0;
      spr_tag <= '0;
      spr_cw  <= '0;
    end else begin
      if (bg_serve) begin
        bg_cv  <= 1'b1;
        bg_tag <= waddr_q;
        bg_cw  <= word_q;
      end
      if (spr_serve) begin
        spr_cv  <= 1'b1;
        spr_tag <= waddr_q;
        spr_cw  <= word_q;
      end
    end
  end
`else
  assign bg_hit    = 1'b0;
  assign spr_hit   = 1'b0;
  assign bg_hbyte  = 8'h00;
  assign spr_hbyte = 8'h00;
`endif

  // A client's in-flight fetch keeps it pending even if read drops.
  always_comb begin
    bg_pend_n = bg_pend;
    if (!bg_read && !bg_fly) bg_pend_n = 1'b0;
    if (bg_det) bg_pend_n = !bg_hit;
    if (bg_serve) bg_pend_n = 1'b0;
    spr_pend_n = spr_pend;
    if (!spr_read && !spr_fly) spr_pend_n = 1'b0;
    if (spr_det) spr_pend_n = !spr_hit;
    if (spr_serve) spr_pend_n = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bg_rd_q   <= 1'b0;
      bg_ad_q   <= '0;
      bg_pend   <= 1'b0;
      bg_valid  <= 1'b0;
      bg_data   <= '0;
      spr_rd_q  <= 1'b0;
      spr_ad_q  <= '0;
      spr_pend  <= 1'b0;
      spr_valid <= 1'b0;
      spr_data  <= '0;
    end else begin
      bg_rd_q  <= bg_read;
      bg_ad_q  <= bg_addr;
      bg_pend  <= bg_pend_n;
      spr_rd_q <= spr_read;
      spr_ad_q <= spr_addr;
      spr_pend <= spr_pend_n;
      if (bg_serve) begin
        bg_valid <= 1'b1;
        bg_data  <= bg_wbyte;
      end else if (bg_hit) begin
        bg_valid <= 1'b1;
        bg_data  <= bg_hbyte;
      end else if (bg_det || !bg_read) begin
        bg_valid <= 1'b0;
      end
      if (spr_serve) begin
        spr_valid <= 1'b1;
        spr_data  <= spr_wbyte;
      end else if (spr_hit) begin
        spr_valid <= 1'b1;
        spr_data  <= spr_hbyte;
      end else if (spr_det || !spr_read) begin
        spr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= OWN_BG;
      waddr_q <= '0;
      word_q  <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      waddr_q <= waddr_n;
      if (state == S_ISSUE && rom_ack) word_q <= rom_data;
    end
  end

  // DONE arbitrates on post-update pending so the next fetch
  // follows after a single idle cycle on rom_req.
  always_comb begin
    state_n = state;
    owner_n = owner;
    waddr_n = waddr_q;
    arb_bg  = (state == S_DONE) ? bg_pend_n : bg_pend;
    arb_spr = (state == S_DONE) ? spr_pend_n : spr_pend;
    unique case (state)
      S_ISSUE: begin
        if (rom_ack) state_n = S_DONE;
      end
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (arb_bg) begin
          state_n = S_ISSUE;
          owner_n = OWN_BG;
          waddr_n = bg_addr[AW-1:1];
        end else if (arb_spr) begin
          state_n = S_ISSUE;
          owner_n = OWN_SPR;
          waddr_n = spr_addr[AW-1:1];
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rom_req  = state == S_ISSUE;
    rom_addr = waddr_q;
  end

endmodule

// File: doc/vball_gfx_server.md
Name: vball_gfx_server

Overview:
- Responder side of the graphics-ROM read interface driven by the tile and sprite renderers.
- Accepts level-style read requests (address plus read strobe) from two clients: BG (priority) and sprite.
- Fetches 16-bit words from the shared ROM/SDRAM port and returns the addressed byte on each client's 8-bit data bus with a valid flag.
- Sits between the renderers and the top-level ROM arbiter.

Parameters:
- AW, 19, client byte-address width; ROM word address is AW-1 bits.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bg_addr  in  AW  BG byte address
- bg_read  in  1  BG read request (level)
- bg_data  out  8  BG returned byte
- bg_valid  out  1  bg_data matches current bg_addr
- spr_addr  in  AW  sprite byte address
- spr_read  in  1  sprite read request (level)
- spr_data  out  8  sprite returned byte
- spr_valid  out  1  spr_data matches current spr_addr
- rom_addr  out  AW-1  ROM word address
- rom_req  out  1  ROM request; held high until ack
- rom_ack  in  1  one-cycle pulse; rom_data valid this cycle
- rom_data  in  16  ROM word; low byte = even address

Behaviour:
- Reset (async): all outputs 0, both pending flags 0, state IDLE, caches invalid.
- Request detection, per client: a new request is registered when the read strobe rises, or when the address changes while read is high.
  - On detection: valid goes 0 next cycle and the pending flag is set.
- Read deasserted: valid goes 0 next cycle; data holds its last value; pending is cleared unless a ROM transaction for that client is in flight.
- Byte select: addr[0]=0 selects rom_data[7:0]; addr[0]=1 selects rom_data[15:8].
- FSM:
  - IDLE
    - If BG pending: go to ISSUE with owner=BG, rom_addr=bg_addr[AW-1:1].
    - Else if sprite pending: go to ISSUE with owner=SPR.
    - BG always wins simultaneous requests.
  - ISSUE: rom_req=1, rom_addr stable; wait for rom_ack.
  - On rom_ack: rom_req=0; capture the word and go to DONE.
  - DONE: compare the captured word address against the owner's current address.
    - Match and read still high: drive data, valid=1, clear pending.
    - Mismatch: pending stays set and the data is discarded.
    - Return to IDLE.
- Only one ROM transaction is outstanding at a time. rom_req never re-asserts in the cycle after ack.
- Miss latency from detection to valid=1: 3 cycles plus ROM ack latency. With ack on the cycle after req, total 5 cycles, within the BG renderer's 9-cycle sampling window.
- rom_ack while not in ISSUE is ignored.
- Reset during ISSUE: rom_req drops immediately; a late ack is ignored.
- Address wrap: the full AW bits are compared. There is no wrap behaviour beyond the natural width.

Optional Feature:
- Macro VBALL_GFX_CACHE_EN.
- Defined:
  - Each client keeps a one-word cache: tag = word address, 16-bit data, valid bit.
  - A detected request whose word address equals a valid tag is a hit.
    - Data and valid=1 are driven one cycle after detection.
    - No ROM request is made; the FSM is not entered.
  - Cache is filled on every DONE match.
  - Cache is invalidated by reset only.
- Undefined: every detected request goes through the FSM; no tag storage is synthesised.

Test Plan:
- After reset, bg_read=1, bg_addr=0x00010; ROM acks 1 cycle after req with 0xBEEF -> rom_addr=0x00008, bg_data=0xEF, bg_valid=1 5 cycles after detection.
- bg_addr=0x00011 and spr_addr=0x20000 raised in the same cycle; ROM data 0x1234 then 0x5678 -> BG served first with bg_data=0x12; spr_data=0x78 after the second ack; rom_req low for one cycle between transactions.
- bg_addr changes 0x00010 -> 0x00020 while ISSUE is active for 0x00010 -> the first result is discarded, bg_valid stays 0, a second request goes out for word 0x00010, and bg_valid=1 with the new byte.
- With VBALL_GFX_CACHE_EN: read 0x00010 then 0x00011 -> the second read is a hit (no rom_req), bg_data=0xBE one cycle after detection. Without the macro: a second ROM transaction is issued.
- Assert reset during ISSUE, then pulse rom_ack -> rom_req=0 immediately, all outputs 0, the ack is ignored, and no valid is asserted.
- bg_read dropped while bg_valid=1 -> bg_valid=0 next cycle and bg_data holds its value.
